sprite_mem_loader: RTL and testbench
====================================

// Module: sprite_mem_loader
// PURPOSE
//  Write-side companion to the sprite palette-index memories. Accepts a byte stream of
//  packed 4-bit palette indices over a valid/ready handshake, unpacks two pixels per
//  byte and drives sequential write strobes into a sprite RAM. Sits between the
//  host/SD streaming logic and the multi-port sprite memory's write port.
// PARAMETERS
//  ADDR_W   19   width of sprite memory address
//  DEPTH    484  number of addressable pixel entries in the target memory
//  PIX_W    4    palette-index width; fixed at 4 (two pixels per byte)
// PORTS
//  Clk            in   1       system clock, all logic rising-edge
//  Reset_n        in   1       asynchronous, active-low reset
//  start          in   1       pulse: begin a load (sampled in IDLE only)
//  base_addr      in   ADDR_W  first pixel address, captured on start
//  pix_count      in   ADDR_W  number of pixels to write, captured on start
//  in_data        in   8       packed pixels: [3:0] first pixel, [7:4] second pixel
//  in_valid       in   1       in_data valid
//  in_ready       out  1       loader accepts in_data this cycle
//  we             out  1       memory write strobe
//  write_address  out  ADDR_W  memory write address
//  data_In        out  PIX_W   memory write data
//  busy           out  1       load in progress
//  done           out  1       one-cycle pulse: load finished normally
//  error          out  1       one-cycle pulse: load rejected (range violation)
//  checksum       out  8       running sum of written pixels (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, Reset_n=0): state IDLE; in_ready, we, busy, done, error = 0;
//    write_address, data_In, checksum = 0; captured base/count cleared.
//  - FSM states: IDLE, RECV, WR_LO, WR_HI.
//  - IDLE: on start=1 capture base_addr/pix_count.
//    * if base_addr + pix_count > DEPTH (ADDR_W+1-bit sum, no wrap): error=1 next cycle, stay IDLE.
//    * else if pix_count==0: done=1 next cycle, stay IDLE, no writes.
//    * else -> RECV, busy=1, addr pointer = base_addr, remaining = pix_count.
//  - RECV: in_ready=1 (registered, asserted exactly while in RECV). Byte transfers when
//    in_valid & in_ready; latch in_data -> WR_LO. No transfer: hold RECV.
//  - WR_LO: we=1, write_address=ptr, data_In=byte[3:0]; ptr++, remaining--.
//    remaining becomes 0 -> IDLE with done=1 (byte[7:4] discarded, odd count); else -> WR_HI.
//  - WR_HI: we=1, data_In=byte[7:4], ptr++, remaining--. remaining 0 -> IDLE + done; else -> RECV.
//  - Latency: byte accepted cycle N -> writes in N+1 (low) and N+2 (high); peak rate 1 byte/3 cycles.
//  - we, write_address, data_In are registered outputs; we deasserted in IDLE and RECV.
//  - done/error: single-cycle pulses, asserted the cycle after the terminating event; busy
//    falls in the same cycle done rises.
//  - start while busy: ignored; no effect on captured values.
//  - in_valid with in_ready=0: no transfer; source must hold data.
//  - Reset mid-load: aborts immediately; partially written memory is not rolled back.
// CONFIGURATION
//  SPRITE_LOADER_CHECKSUM_EN defined: checksum accumulates (8-bit, wraps mod 256) each data_In
//    value on every we=1 cycle; cleared to 0 on accepted start; holds after done until next start.
//  Undefined: checksum tied to 8'h00, no accumulator logic.
// TESTING
//  1. Reset, start base=0 count=4, bytes 8'h21, 8'h43 -> writes (0,1)(1,2)(2,3)(3,4), one done pulse.
//  2. start base=10 count=3, bytes 8'hBA, 8'hFC -> writes (10,A)(11,B)(12,C); nibble F never written.
//  3. start base=480 count=5 -> error pulse next cycle, in_ready stays 0, no we.
//  4. count=0 -> done pulse, no we; start asserted again while busy in a load -> ignored.
//  5. Stall in_valid low 5 cycles mid-load; assert Reset_n=0 during WR_HI -> all outputs 0 async.
//  6. CHECKSUM_EN: test 1 -> checksum=8'h0A; without macro checksum=8'h00 throughout.

Source files
------------

// File: rtl/sprite_mem_loader.sv
// sprite_mem_loader: unpacks a byte stream of 4-bit palette indices into sequential sprite RAM writes.
// Optional feature macro: SPRITE_LOADER_CHECKSUM_EN enables the running 8-bit checksum of written pixels.
module sprite_mem_loader #(
    parameter int ADDR_W = 19,
    parameter int DEPTH  = 484,
    parameter int PIX_W  = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] pix_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] write_address,
    output logic [PIX_W-1:0]  data_In,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        checksum
);
    typedef enum logic [1:0] {IDLE, RECV, WR_LO, WR_HI} state_t;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, rem_q, rem_d, addr_q, addr_d;
    logic [7:0]        byte_q, byte_d;
    logic [PIX_W-1:0]  data_q, data_d;
    logic              in_ready_q, in_ready_d, we_q, we_d, busy_q, busy_d;
    logic              done_q, done_d, error_q, error_d;
    logic              range_err, start_ok, xfer, in_wr, last;

    // The sum is one bit wider than the address so a range overflow cannot wrap.
    assign range_err = ({1'b0, base_addr} + {1'b0, pix_count}) > LIMIT;
    assign start_ok  = state_q == IDLE && start && !range_err;
    assign xfer      = state_q == RECV && in_valid && in_ready_q;
    assign in_wr     = state_q == WR_LO || state_q == WR_HI;
    assign last      = rem_q == ADDR_W'(1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            addr_q     <= '0;
            byte_q     <= '0;
            data_q     <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            byte_q     <= byte_d;
            data_q     <= data_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = (start_ok && pix_count != '0) ? RECV : IDLE;
            RECV:  state_d = xfer ? WR_LO : RECV;
            WR_LO: state_d = last ? IDLE : WR_HI;
            WR_HI: state_d = last ? IDLE : RECV;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d      = start_ok ? base_addr : (in_wr ? ptr_q + ADDR_W'(1) : ptr_q);
        rem_d      = start_ok ? pix_count : (in_wr ? rem_q - ADDR_W'(1) : rem_q);
        byte_d     = xfer ? in_data : byte_q;
        addr_d     = xfer ? ptr_q : ((state_q == WR_LO && !last) ? ptr_q + ADDR_W'(1) : addr_q);
        data_d     = xfer ? in_data[3:0] : ((state_q == WR_LO && !last) ? byte_q[7:4] : data_q);
        in_ready_d = state_d == RECV;
        we_d       = state_d == WR_LO || state_d == WR_HI;
        busy_d     = state_d != IDLE;
        done_d     = (start_ok && pix_count == '0) || (in_wr && last);
        error_d    = state_q == IDLE && start && range_err;
    end

    assign in_ready      = in_ready_q;
    assign we            = we_q;
    assign write_address = addr_q;
    assign data_In       = data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [7:0] cks_q, cks_d;

    always_comb cks_d = start_ok ? 8'h00 : cks_q + (we_q ? 8'(data_q) : 8'h00);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) cks_q <= 8'h00;
        else          cks_q <= cks_d;
    end

    assign checksum = cks_q;
`else
    assign checksum = 8'h00;
`endif
endmodule

// File: tb/tb_sprite_mem_loader.sv
// tb_sprite_mem_loader: directed and randomized loads checked against a pixel-list reference model.
// Build with SPRITE_LOADER_CHECKSUM_EN defined to also check the checksum accumulator.
module tb_sprite_mem_loader;
    localparam int ADDR_W = 19;
    localparam int DEPTH  = 484;

    logic              Clk = 1'b0, Reset_n = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0, pix_count = '0;
    logic [7:0]        in_data = '0;
    logic              in_ready, we, busy, done, error;
    logic [ADDR_W-1:0] write_address;
    logic [3:0]        data_In;
    logic [7:0]        checksum;

    int checks = 0, errors = 0, done_cnt = 0, err_cnt = 0, rdy_cnt = 0;
    logic [ADDR_W+3:0] obs[$];
    logic [7:0]        feed[$];
    logic [7:0]        exp_cks = 8'h00;

    always #5 Clk = ~Clk;

    sprite_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PIX_W(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .base_addr(base_addr),
        .pix_count(pix_count), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .we(we), .write_address(write_address),
        .data_In(data_In), .busy(busy), .done(done), .error(error), .checksum(checksum)
    );

    always @(negedge Clk) begin
        if (we === 1'b1) obs.push_back({write_address, data_In});
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (in_ready === 1'b1) rdy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 0);
        chk({tag, "_we"}, 32'(we), 0);
        chk({tag, "_addr"}, 32'(write_address), 0);
        chk({tag, "_data"}, 32'(data_In), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_cks"}, 32'(checksum), 0);
    endtask

    task automatic run_load(input int base, input int count, input bit stall, input bit poke);
        int         nb  = (count + 1) / 2;
        bit         bad = (base + count) > DEPTH;
        int         t;
        logic [7:0] sum = 8'h00;
        logic [7:0] b;
        logic [3:0] nib;
        while (feed.size() < nb) feed.push_back(8'($urandom));
        obs.delete();
        done_cnt = 0; err_cnt = 0; rdy_cnt = 0;
        base_addr = ADDR_W'(base); pix_count = ADDR_W'(count); start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        if (!bad) for (int i = 0; i < nb; i++) begin
            if (stall) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 5)) @(negedge Clk);
            end
            in_valid = 1'b1; in_data = feed[i];
            if (poke && i == 0) begin
                start = 1'b1; base_addr = ADDR_W'(5); pix_count = ADDR_W'(1);
            end
            t = 0;
            while (in_ready !== 1'b1 && t < 50) begin @(negedge Clk); t++; end
            chk("ready_wait", 32'(t < 50), 1);
            @(negedge Clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        t = 0;
        while (done_cnt + err_cnt == 0 && t < 40) begin @(negedge Clk); t++; end
        repeat (3) @(negedge Clk);
        chk("done_pulses", 32'(done_cnt), bad ? 0 : 1);
        chk("error_pulses", 32'(err_cnt), bad ? 1 : 0);
        if (bad) chk("ready_on_error", 32'(rdy_cnt), 0);
        chk("write_count", 32'(obs.size()), bad ? 0 : count);
        for (int i = 0; i < count && !bad; i++) begin
            b   = feed[i/2];
            nib = (i % 2 == 1) ? b[7:4] : b[3:0];
            sum += 8'(nib);
            chk("write", (i < obs.size()) ? 32'(obs[i]) : 32'hxxxxxxxx, 32'({ADDR_W'(base + i), nib}));
        end
        if (!bad) exp_cks = sum;
        chk("busy_idle", 32'(busy), 0);
`ifdef SPRITE_LOADER_CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'(exp_cks));
`else
        chk("checksum", 32'(checksum), 0);
`endif
        feed.delete();
    endtask

    initial begin
        #1 Reset_n = 1'b0;
        #2 all_zero("reset");
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        all_zero("post_reset");

        feed = '{8'h21, 8'h43};
        run_load(0, 4, 1'b0, 1'b0);
        feed = '{8'hBA, 8'hFC};
        run_load(10, 3, 1'b0, 1'b0);
        run_load(480, 5, 1'b0, 1'b0);
        run_load(480, 4, 1'b0, 1'b0);
        run_load(483, 1, 1'b0, 1'b0);
        run_load(0, 0, 1'b0, 1'b0);
        run_load(30, 7, 1'b1, 1'b1);

        feed = '{8'($urandom), 8'($urandom), 8'($urandom)};
        obs.delete();
        base_addr = ADDR_W'(20); pix_count = ADDR_W'(6); start = 1'b1;
        @(negedge Clk);
        start = 1'b0; in_valid = 1'b1; in_data = feed[0];
        @(negedge Clk);
        in_valid = 1'b0;
        chk("we_lo", 32'(we), 1);
        @(negedge Clk);
        chk("we_hi", 32'(we), 1);
        chk("hi_data", 32'(data_In), 32'(feed[0][7:4]));
        #2 Reset_n = 1'b0;
        #1 all_zero("async_reset");
        chk("writes_before_reset", 32'(obs.size()), 2);
        @(negedge Clk);
        Reset_n = 1'b1;
        exp_cks = 8'h00;
        feed.delete();
        @(negedge Clk);

        for (int k = 0; k < 10; k++) begin
            int base = (k % 3 == 0) ? int'($urandom_range(470, 483)) : int'($urandom_range(0, 400));
            run_load(base, int'($urandom_range(0, 15)), k[0], k == 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
